// File: rtl/booth_mul_iter_if.sv
// Request/result handshake bundle between the EXU issue stage and the
// iterative Booth multiplier.
interface booth_mul_iter_if #(
  parameter int unsigned XLEN = 64
);
  logic            mul_valid;
  logic            mul_ready;
  logic            flush;
  logic            mulw;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  modport master (
    output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: one partial product accumulated per
// cycle, serving RV64M mul/mulh/mulhsu/mulhu/mulw.
module booth_mul_iter #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ITER   = 33,
  parameter int unsigned ITER_W = 17
) (
  input logic         clk,
  input logic         rst_n,
  booth_mul_iter_if.slave bus
);
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned YW = XLEN + 3;
  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_w_q, is_w_d;
  logic            mul_ready_q, mul_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] res_hi_q, res_hi_d;
  logic [XLEN-1:0] res_lo_q, res_lo_d;

  logic [PW-1:0]   pp;
  logic            neg;
  logic            last;
  logic            sa, sb;

  always_comb begin
    pp  = '0;
    neg = 1'b0;
    unique case (y_q[2:0])
      3'b001, 3'b010: pp = x_q;
      3'b011:         pp = x_q << 1;
      3'b100: begin
        pp  = ~(x_q << 1);
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp  = ~x_q;
        neg = 1'b1;
      end
      default:        pp = '0;
    endcase
  end

  assign last = (cnt_q == (is_w_q ? CW'(ITER_W - 1) : CW'(ITER - 1)));
  assign sa   = bus.mul_signed[1] & bus.multiplicand[XLEN-1];
  assign sb   = bus.mul_signed[0] & bus.multiplier[XLEN-1];

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    is_w_d   = is_w_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.flush && bus.mul_valid) begin
          state_d = BUSY;
          acc_d   = '0;
          cnt_d   = '0;
          is_w_d  = bus.mulw;
          // mulw treats both low words as signed, ignoring mul_signed
          if (bus.mulw) begin
            x_d = {{(PW-32){bus.multiplicand[31]}}, bus.multiplicand[31:0]};
            y_d = {{(YW-33){bus.multiplier[31]}}, bus.multiplier[31:0], 1'b0};
          end else begin
            x_d = {{XLEN{sa}}, bus.multiplicand};
            y_d = {sb, sb, bus.multiplier, 1'b0};
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + pp + {{(PW-1){1'b0}}, neg};
          x_d   = x_q << 2;
          y_d   = {{2{y_q[YW-1]}}, y_q[YW-1:2]};
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = DONE;
            if (is_w_q) begin
              res_hi_d = '0;
              res_lo_d = {{(XLEN-32){acc_d[31]}}, acc_d[31:0]};
            end else begin
              res_hi_d = acc_d[PW-1:XLEN];
              res_lo_d = acc_d[XLEN-1:0];
            end
          end
        end
      end
      DONE: begin
        if (bus.flush || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mul_ready_d = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      is_w_q      <= 1'b0;
      mul_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      is_w_q      <= is_w_d;
      mul_ready_q <= mul_ready_d;
      out_valid_q <= out_valid_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
    end
  end

  assign bus.mul_ready = mul_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;
endmodule

// File: tb/tb_booth_mul_iter.sv
// Directed self-checking bench for booth_mul_iter with hand-computed products.
module tb_booth_mul_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;
  int   seen;
  logic [63:0] held_hi, held_lo;

  booth_mul_iter_if #(.XLEN(64)) bus ();

  booth_mul_iter #(.XLEN(64), .ITER(33), .ITER_W(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; return edges from accept until out_valid (100 = timeout).
  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] s, input logic w, output int edges);
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.mul_signed   = s;
    bus.mulw         = w;
    bus.mul_valid    = 1'b1;
    @(posedge clk); #1;
    bus.mul_valid    = 1'b0;
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
    bus.mul_signed   = 2'($urandom);
    bus.mulw         = ~w;
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("consume_ready", 64'(bus.mul_ready), 64'd1);
    check("consume_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.mul_valid    = 1'b0;
    bus.flush        = 1'b0;
    bus.mulw         = 1'b0;
    bus.mul_signed   = 2'b00;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.out_ready    = 1'b0;
    #12;
    check("rst_ready", 64'(bus.mul_ready), 64'd1);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_hi", bus.result_hi, 64'd0);
    check("rst_lo", bus.result_lo, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, lat);
    check("mulhu_lat", 64'(lat), 64'd33);
    check("mulhu_hi", bus.result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mulhu_lo", bus.result_lo, 64'h0000_0000_0000_0001);
    consume();

    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, lat);
    check("mulh_lat", 64'(lat), 64'd33);
    check("mulh_hi", bus.result_hi, 64'd0);
    check("mulh_lo", bus.result_lo, 64'd1);
    consume();

    start_op(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, lat);
    check("mulhsu_hi", bus.result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mulhsu_lo", bus.result_lo, 64'h0000_0000_0000_0002);
    consume();

    start_op(64'h1234_5678_7FFF_FFFF, 64'h2, 2'b00, 1'b1, lat);
    check("mulw_lat", 64'(lat), 64'd17);
    check("mulw_hi", bus.result_hi, 64'd0);
    check("mulw_lo", bus.result_lo, 64'hFFFF_FFFF_FFFF_FFFE);
    consume();

    // back-pressure: result must hold, new requests ignored
    start_op(64'd6, 64'd7, 2'b00, 1'b0, lat);
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    bus.mul_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_lo", bus.result_lo, 64'd42);
      check("bp_hold_hi", bus.result_hi, 64'd0);
      check("bp_ready", 64'(bus.mul_ready), 64'd0);
      check("bp_valid_hold", 64'(bus.out_valid), 64'd1);
    end
    bus.mul_valid = 1'b0;
    consume();

    // flush at iteration 5 with a competing request
    @(negedge clk);
    bus.multiplicand = 64'd9;
    bus.multiplier   = 64'd9;
    bus.mul_signed   = 2'b00;
    bus.mulw         = 1'b0;
    bus.mul_valid    = 1'b1;
    @(posedge clk); #1;
    bus.mul_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.flush     = 1'b1;
    bus.mul_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.mul_valid = 1'b0;
    check("flush_ready", 64'(bus.mul_ready), 64'd1);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1 || bus.mul_ready !== 1'b1) seen++;
    end
    check("flush_quiet", 64'(seen), 64'd0);

    start_op(64'd3, 64'd5, 2'b00, 1'b0, lat);
    check("post_flush_lo", bus.result_lo, 64'd15);
    check("post_flush_hi", bus.result_hi, 64'd0);

    // flush in DONE drops the result but keeps the data
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("dflush_valid", 64'(bus.out_valid), 64'd0);
    check("dflush_ready", 64'(bus.mul_ready), 64'd1);
    check("dflush_lo", bus.result_lo, 64'd15);

    // async reset mid-BUSY
    @(negedge clk);
    bus.multiplicand = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.multiplier   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.mul_signed   = 2'b00;
    bus.mul_valid    = 1'b1;
    @(posedge clk); #1;
    bus.mul_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(bus.mul_ready), 64'd1);
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_hi", bus.result_hi, 64'd0);
    check("arst_lo", bus.result_lo, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 2'b11, 1'b0, lat);
    check("neg_lat", 64'(lat), 64'd33);
    check("neg_hi", bus.result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
    check("neg_lo", bus.result_lo, 64'hFFFF_FFFF_FFFF_FFEB);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/booth_mul_iter.md
Name: booth_mul_iter

Overview:
- Iterative radix-4 Booth multiplier for the NPC EXU.
- Consumes one Booth partial product per cycle (128-bit p plus negate carry c) and accumulates it into a 128-bit product.
- Serves RV64M mul/mulh/mulhsu/mulhu/mulw through a valid/ready request side and a valid/ready result side.
- Sits between the EXU operand issue and the writeback mux.

Parameters:
- XLEN, 64, operand width; product is 2*XLEN.
- ITER, 33, Booth iterations for full-width operands (XLEN+2 extended multiplier bits / 2).
- ITER_W, 17, Booth iterations for mulw (34 extended bits / 2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mul_valid  input  1  request valid.
- mul_ready  output  1  block idle, can accept a request.
- flush  input  1  abort current operation.
- mulw  input  1  32-bit word multiply.
- mul_signed  input  2  [1] multiplicand signed, [0] multiplier signed.
- multiplicand  input  64  operand A.
- multiplier  input  64  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result_hi  output  64  product[127:64].
- result_lo  output  64  product[63:0].

Behaviour:
- Reset (async, rst_n=0): state IDLE, mul_ready=1, out_valid=0, result_hi=0, result_lo=0, accumulator/counter cleared. Reset mid-operation discards all work.
- States:
  - IDLE -> BUSY on mul_valid & mul_ready & ~flush.
  - BUSY -> DONE after the final iteration.
  - DONE -> IDLE on out_ready.
  - Any state -> IDLE on flush.
- Outputs by state:
  - mul_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- Accept edge (operand extension):
  - Multiplicand extended to 66 bits (sign bit = mul_signed[1] ? A[63] : 0), then sign-extended to 128 bits into the shift register X.
  - Multiplier extended likewise with mul_signed[0] to 66 bits; a 0 is appended below the LSB to form 67-bit register Y.
  - mulw: only A[31:0] and B[31:0] are used, both treated signed regardless of mul_signed; extended to 34 bits; iteration target ITER_W.
  - Accumulator cleared; counter cleared.
- Each BUSY cycle, window src = Y[2:0] = {y+1, y, y-1} selects the partial product:
  - 000/111: 0.
  - 001/010: +X, c=0.
  - 011: +2X, c=0.
  - 100: ~(X<<1), c=1.
  - 101/110: ~X, c=1.
  - acc <= acc + p + c (mod 2^128); X <= X<<2; Y <= Y>>>2 (arithmetic); counter++.
- Last iteration is counter==ITER-1 (ITER_W-1 for mulw); that edge also registers the results and enters DONE.
- Latency: out_valid rises on the 33rd rising edge after the accepting edge (17th for mulw).
- Result registration:
  - Full width: result_hi=acc[127:64], result_lo=acc[63:0].
  - mulw: result_lo = sign-extend(acc[31:0]), result_hi = 0.
- Results held stable while out_valid=1 and out_ready=0 (unbounded back-pressure).
- DONE & out_ready: IDLE on the next edge; a new request is accepted no earlier than the edge after that.
- flush:
  - Priority over accept and out_ready in the same cycle; no request accepted on a flush cycle.
  - In DONE, flush drops the result (out_valid=0 next edge); result_hi/lo are not cleared.
- mul_valid while not IDLE is ignored; operands are sampled only on the accepting edge.
- Operand inputs may change freely after acceptance.

Test Plan:
- Unsigned: A=B=0xFFFF_FFFF_FFFF_FFFF, mul_signed=00 -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x0000_0000_0000_0001; out_valid exactly 33 edges after accept.
- Signed: A=B=0xFFFF_FFFF_FFFF_FFFF, mul_signed=11 -> hi=0, lo=1.
- Signed x unsigned (mulhsu): A=0xFFFF_FFFF_FFFF_FFFE, B=0xFFFF_FFFF_FFFF_FFFF, mul_signed=10 -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x0000_0000_0000_0002.
- mulw: A=0x1234_5678_7FFF_FFFF, B=0x2, mulw=1 -> lo=0xFFFF_FFFF_FFFF_FFFE, hi=0; out_valid after 17 edges.
- Back-pressure and flush:
  - out_ready=0 for 10 cycles -> result stable, mul_ready=0 throughout.
  - Next op flushed at iteration 5 -> out_valid never rises, mul_ready=1 next edge.
  - Following 3x5 -> lo=15.
- Reset: rst_n pulsed low mid-BUSY between clock edges -> outputs zero immediately; after release, 7x(-3) signed -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFEB.
